aidan_mcnay_sipo_framed: RTL and testbench
==========================================

// Module: aidan_mcnay_sipo_framed
// PURPOSE
//   Framed serial-in/parallel-out deserialiser that feeds parallel candidates to the prime-detection datapath.
//   - Counts incoming bits and assembles each NBITS-bit word.
//   - Places each completed word in a one-entry holding register with a valid/ready output handshake.
//   - Flags overrun when a word completes while the previous word has not been drained.
//   - Successor to the plain en-gated shift register: adds selectable bit order, framing, handshake and overrun detection.
// PARAMETERS
//   NBITS      16  word width in bits; legal range 2..64
//   MSB_FIRST  1   1 = first serial bit lands in data_out[NBITS-1]; 0 = first serial bit lands in data_out[0]
// PORTS
//   clk        in   1                      single clock; all flops rising-edge
//   reset      in   1                      asynchronous, active-low reset
//   clear      in   1                      synchronous frame abort; discards the partial word and the held word
//   en         in   1                      data_in is sampled on this edge
//   data_in    in   1                      serial data bit
//   out_valid  out  1                      holding register holds a word
//   out_ready  in   1                      consumer accepts the word when out_valid && out_ready
//   data_out   out  NBITS                  held word; stable while out_valid && !out_ready
//   bit_count  out  $clog2(NBITS_TOT+1)    bits collected in the current frame
//   overrun    out  1                      sticky; set when a completed word is dropped
//   parity_err out  1                      qualified by out_valid; tied 0 unless SIPO_PARITY_EN is defined
// BEHAVIOUR
//   Reset (reset=0, asynchronous): shift reg=0, bit_count=0, data_out=0, out_valid=0, overrun=0, parity_err=0.
//   NBITS_TOT = NBITS, or NBITS+1 when SIPO_PARITY_EN is defined.
//   Priority each edge: clear > en.
//   clear=1: bit_count=0, shift reg=0, out_valid=0, overrun=0, parity_err=0; en in the same cycle is ignored.
//   Shift on en=1:
//     MSB_FIRST=1: sr <= {sr[NBITS-2:0], data_in}.
//     MSB_FIRST=0: sr <= {data_in, sr[NBITS-1:1]}.
//   Counting on en=1: bit_count increments, wrapping to 0 on the edge that samples bit NBITS_TOT-1 (word completes).
//   With SIPO_PARITY_EN, the parity bit is not shifted into sr.
//   Latency: out_valid=1 in the cycle after the edge that samples the last bit; data_out equals the new word in that cycle.
//   Handshake: the word drains on any edge with out_valid && out_ready; out_valid falls unless a new word completes on the same edge.
//   Word completes, holding register empty or draining on the same edge:
//     data_out loads, out_valid=1; back-to-back words sustain without bubbles.
//   Word completes while out_valid && !out_ready:
//     new word is dropped; data_out and out_valid are held; overrun sets and stays 1 until clear or reset.
//   en=0 edges: no shift, no count change; handshake still operates.
//   reset mid-frame: partial word is lost; the next en starts bit 0 of a new frame.
//   State: COLLECT (bit_count < NBITS_TOT) x HOLD{EMPTY,FULL}; no other states; no illegal encodings are reachable.
// CONFIGURATION
//   SIPO_PARITY_EN defined:
//     - each frame is NBITS data bits followed by one even-parity bit.
//     - parity_err = ^{word, parity_bit}, latched with data_out.
//     - a dropped word does not update parity_err.
//   SIPO_PARITY_EN undefined:
//     - frame = NBITS bits; parity_err is a constant 0.
//     - the port list is identical in both builds.
// STRUCTURE
//   Package aidan_mcnay_sipo_pkg:
//     - function cnt_width(n) returning $clog2(n+1).
//     - localparam SIPO_MAX_NBITS = 64.
//   Sub-module aidan_mcnay_sipo_hold #(NBITS+1): one-entry valid/ready holding register with overrun detect.
//     - payload = {parity_err, word}.
//   Top level: shift register, bit counter and parity accumulator.
// TESTING
//   T1 NBITS=16, MSB_FIRST=1: shift 0xB00B MSB first with en=1, out_ready=1 -> out_valid high for 1 cycle after bit 15; data_out=0xB00B; bit_count back to 0.
//   T2 MSB_FIRST=0: shift 0x0007 LSB first with en toggling 1,0,1,0 -> data_out=0x0007 only after 16 en-qualified bits; bit_count unchanged on en=0 cycles.
//   T3 out_ready=0: shift 0x1234 then 0x5678 -> data_out stays 0x1234; overrun=1 after bit 15 of word 2; raise out_ready -> out_valid falls; overrun stays 1 until clear.
//   T4 out_ready=1 on the same edge word 2 completes, words back-to-back -> out_valid stays 1; data_out steps 0x1234 -> 0x5678; overrun=0.
//   T5 reset pulsed low after 7 bits (async, mid-cycle) -> all outputs 0 immediately; then 16 bits of 0x00FF -> data_out=0x00FF.
//   T6 SIPO_PARITY_EN: 0x0003 + parity 0 -> parity_err=0; 0x0003 + parity 1 -> parity_err=1; clear with en=1 -> bit_count=0, no shift.

Source files
------------

// File: rtl/aidan_mcnay_sipo_pkg.sv
// Shared constants and helpers for the framed SIPO deserialiser.
// SIPO_PARITY_EN adds one trailing even-parity bit to every frame.
package aidan_mcnay_sipo_pkg;

  localparam int SIPO_MAX_NBITS = 64;

`ifdef SIPO_PARITY_EN
  localparam int SIPO_PARITY_BITS = 1;
`else
  localparam int SIPO_PARITY_BITS = 0;
`endif

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/aidan_mcnay_sipo_hold.sv
// One-entry valid/ready holding register with sticky overrun detection.
module aidan_mcnay_sipo_hold
  import aidan_mcnay_sipo_pkg::*;
#(
  parameter int W = SIPO_MAX_NBITS + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         overrun
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         ovr_q, ovr_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = '0;
      ovr_d   = 1'b0;
    end else if (in_valid && (!valid_q || out_ready)) begin
      // Empty or draining this edge: take the new word with no bubble.
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (in_valid) begin
      ovr_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign overrun   = ovr_q;

endmodule

// File: rtl/aidan_mcnay_sipo_framed.sv
// Framed serial-in/parallel-out deserialiser with valid/ready output and overrun flag.
// Optional trailing even-parity bit per frame when SIPO_PARITY_EN is defined.
module aidan_mcnay_sipo_framed
  import aidan_mcnay_sipo_pkg::*;
#(
  parameter int NBITS     = 16,
  parameter bit MSB_FIRST = 1'b1,
  localparam int NBITS_TOT = NBITS + SIPO_PARITY_BITS,
  localparam int CW        = cnt_width(NBITS_TOT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] data_out,
  output logic [CW-1:0]    bit_count,
  output logic             overrun,
  output logic             parity_err
);

  logic [NBITS-1:0] sr_q, sr_d, shifted, word;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit, data_bit, parity;

  if (MSB_FIRST) begin : g_msb
    assign shifted = {sr_q[NBITS-2:0], data_in};
  end else begin : g_lsb
    assign shifted = {data_in, sr_q[NBITS-1:1]};
  end

  assign last_bit = en && (cnt_q == CW'(NBITS_TOT - 1));

`ifdef SIPO_PARITY_EN
  // The trailing parity bit is checked against the already-assembled word, never shifted in.
  assign data_bit = (cnt_q < CW'(NBITS));
  assign word     = sr_q;
  assign parity   = ^{sr_q, data_in};
`else
  assign data_bit = 1'b1;
  assign word     = shifted;
  assign parity   = 1'b0;
`endif

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (en) begin
      if (data_bit) sr_d = shifted;
      cnt_d = last_bit ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  aidan_mcnay_sipo_hold #(.W(NBITS + 1)) u_hold (
    .clk      (clk),
    .rst_n    (reset),
    .clear    (clear),
    .in_valid (last_bit && !clear),
    .in_data  ({parity, word}),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data ({parity_err, data_out}),
    .overrun  (overrun)
  );

  assign bit_count = cnt_q;

endmodule

// File: tb/tb_aidan_mcnay_sipo_framed.sv
// Bench for aidan_mcnay_sipo_framed: MSB-first and LSB-first instances checked against a positional model.
module tb_aidan_mcnay_sipo_framed;

  localparam int NB = 16;
`ifdef SIPO_PARITY_EN
  localparam int NT = NB + 1;
`else
  localparam int NT = NB;
`endif
  localparam int CW = $clog2(NT + 1);

  logic clk = 1'b0;
  logic reset, clear, en, data_in, out_ready;
  bit   checking = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam bit MF = (gi == 0);

    logic          ov, ovr, perr;
    logic [NB-1:0] dout;
    logic [CW-1:0] cnt;

    aidan_mcnay_sipo_framed #(.NBITS(NB), .MSB_FIRST(MF)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .en        (en),
      .data_in   (data_in),
      .out_valid (ov),
      .out_ready (out_ready),
      .data_out  (dout),
      .bit_count (cnt),
      .overrun   (ovr),
      .parity_err(perr)
    );

    // Model: each serial bit is placed straight at its final word position.
    logic [NB-1:0] m_word_q, m_data_q, w_next;
    logic          m_valid_q, m_ovr_q, m_perr_q, done, p_next;
    int            m_cnt_q, idx, ones;

    always_comb begin
      w_next = m_word_q;
      idx    = MF ? (NB - 1 - m_cnt_q) : m_cnt_q;
      if (m_cnt_q < NB) w_next[idx] = data_in;
      done = en && (m_cnt_q == NT - 1);
      ones = $countones(w_next);
      if (NT > NB && data_in) ones = ones + 1;
      p_next = (NT > NB) && ((ones % 2) == 1);
    end

    always @(posedge clk or negedge reset) begin
      if (!reset || clear) begin
        m_word_q  <= '0;
        m_data_q  <= '0;
        m_valid_q <= 1'b0;
        m_ovr_q   <= 1'b0;
        m_perr_q  <= 1'b0;
        m_cnt_q   <= 0;
      end else begin
        if (en) begin
          m_word_q <= w_next;
          m_cnt_q  <= done ? 0 : m_cnt_q + 1;
        end
        if (done) begin
          if (!m_valid_q || out_ready) begin
            m_data_q  <= w_next;
            m_perr_q  <= p_next;
            m_valid_q <= 1'b1;
          end else begin
            m_ovr_q <= 1'b1;
          end
        end else if (m_valid_q && out_ready) begin
          m_valid_q <= 1'b0;
        end
      end
    end

    always @(negedge clk) begin
      if (checking && reset === 1'b1) begin
        chk($sformatf("dut%0d out_valid", gi), 64'(ov), 64'(m_valid_q));
        chk($sformatf("dut%0d data_out", gi), 64'(dout), 64'(m_data_q));
        chk($sformatf("dut%0d bit_count", gi), 64'(cnt), 64'(m_cnt_q));
        chk($sformatf("dut%0d overrun", gi), 64'(ovr), 64'(m_ovr_q));
        chk($sformatf("dut%0d parity_err", gi), 64'(perr), 64'(m_perr_q));
        if (ov && out_ready)
          $display("dut%0d word accepted data_out=0x%04h parity_err=%0b", gi, dout, perr);
      end
    end
  end

  task automatic tick(input logic e, input logic d);
    en      = e;
    data_in = d;
    @(negedge clk);
  endtask

  // rdy_last >= 0 sets out_ready just before the edge that completes the frame.
  task automatic send_word(input logic [NB-1:0] w, input bit msb, input bit gap, input int rdy_last);
    for (int i = 0; i < NB; i++) begin
      if (gap && i > 0) tick(1'b0, 1'b0);
      if (NT == NB && i == NB - 1 && rdy_last >= 0) out_ready = rdy_last[0];
      tick(1'b1, msb ? w[NB-1-i] : w[i]);
    end
    if (NT > NB) begin
      if (gap) tick(1'b0, 1'b0);
      if (rdy_last >= 0) out_ready = rdy_last[0];
      tick(1'b1, ^w);
    end
    en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; en = 1'b0; data_in = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset out_valid", 64'(g_dut[0].ov), 64'd0);
    chk("reset data_out", 64'(g_dut[0].dout), 64'd0);
    chk("reset bit_count", 64'(g_dut[0].cnt), 64'd0);
    reset = 1'b1;
    checking = 1'b1;
    @(negedge clk);

    // T1: 0xB00B MSB first; LSB-first instance sees it bit-reversed.
    send_word(16'hB00B, 1'b1, 1'b0, -1);
    chk("T1 out_valid", 64'(g_dut[0].ov), 64'd1);
    chk("T1 data_out", 64'(g_dut[0].dout), 64'hB00B);
    chk("T1 rev data_out", 64'(g_dut[1].dout), 64'hD00D);
    chk("T1 bit_count", 64'(g_dut[0].cnt), 64'd0);
    tick(1'b0, 1'b0);
    chk("T1 valid falls", 64'(g_dut[0].ov), 64'd0);

    // T2: 0x0007 LSB first with idle cycles between bits.
    send_word(16'h0007, 1'b0, 1'b1, -1);
    chk("T2 lsb data_out", 64'(g_dut[1].dout), 64'h0007);
    chk("T2 msb data_out", 64'(g_dut[0].dout), 64'hE000);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    chk("T2 count after en", 64'(g_dut[0].cnt), 64'd1);
    tick(1'b0, 1'b0);
    chk("T2 count held", 64'(g_dut[0].cnt), 64'd1);
    clear = 1'b1;
    tick(1'b1, 1'b1);
    clear = 1'b0;
    chk("T6 clear bit_count", 64'(g_dut[0].cnt), 64'd0);
    en = 1'b0;

    // T3: consumer stalled across two words.
    out_ready = 1'b0;
    send_word(16'h1234, 1'b1, 1'b0, -1);
    send_word(16'h5678, 1'b1, 1'b0, -1);
    chk("T3 data held", 64'(g_dut[0].dout), 64'h1234);
    chk("T3 overrun", 64'(g_dut[0].ovr), 64'd1);
    out_ready = 1'b1;
    tick(1'b0, 1'b0);
    chk("T3 valid falls", 64'(g_dut[0].ov), 64'd0);
    chk("T3 overrun sticky", 64'(g_dut[0].ovr), 64'd1);
    clear = 1'b1;
    tick(1'b0, 1'b0);
    clear = 1'b0;
    chk("T3 overrun cleared", 64'(g_dut[0].ovr), 64'd0);

    // T4: drain and reload on the same edge.
    send_word(16'h1234, 1'b1, 1'b0, -1);
    chk("T4 first word", 64'(g_dut[0].dout), 64'h1234);
    out_ready = 1'b0;
    send_word(16'h5678, 1'b1, 1'b0, 1);
    chk("T4 out_valid", 64'(g_dut[0].ov), 64'd1);
    chk("T4 data_out", 64'(g_dut[0].dout), 64'h5678);
    chk("T4 overrun", 64'(g_dut[0].ovr), 64'd0);

    // T5: asynchronous reset mid-frame.
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1);
    en = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("T5 out_valid", 64'(g_dut[0].ov), 64'd0);
    chk("T5 data_out", 64'(g_dut[0].dout), 64'd0);
    chk("T5 bit_count", 64'(g_dut[0].cnt), 64'd0);
    #1 reset = 1'b1;
    @(negedge clk);
    send_word(16'h00FF, 1'b1, 1'b0, -1);
    chk("T5 data_out new", 64'(g_dut[0].dout), 64'h00FF);

`ifdef SIPO_PARITY_EN
    // T6: explicit good and bad parity bits.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NB; i++) tick(1'b1, (i >= NB - 2));
      tick(1'b1, p[0]);
      en = 1'b0;
      chk($sformatf("T6 data p=%0d", p), 64'(g_dut[0].dout), 64'h0003);
      chk($sformatf("T6 parity_err p=%0d", p), 64'(g_dut[0].perr), 64'(p));
    end
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
